// File: rtl/dmem_dma.sv
// Word-granular DMA engine between two regions of one data memory.
// Each word is read (RD), captured (CAP) and written (WR), in ascending order.
// The transfer stalls while mem_stall is high.
// An optional fill mode is enabled by defining DMEM_DMA_FILL_EN.
// In fill mode the engine writes one constant word to the destination range and skips the reads.
module dmem_dma #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] len,
`ifdef DMEM_DMA_FILL_EN
  input  logic             fill,
  input  logic [31:0]      fill_data,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mem_address,
  output logic [31:0]      mem_data_in,
  output logic             mem_write,
  output logic             mem_read,
  input  logic [31:0]      mem_data_out,
  input  logic             mem_stall
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StWr,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] src_q, src_d;
  logic [WIDTH-1:0] dst_q, dst_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
`ifdef DMEM_DMA_FILL_EN
  logic             fill_q, fill_d;
`endif

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef DMEM_DMA_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef DMEM_DMA_FILL_EN
      fill_q  <= fill_d;
`endif
    end
  end

  // Next-state logic: sequence through the states and step the addresses and remaining count.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef DMEM_DMA_FILL_EN
    fill_d  = fill_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          if (len == '0) begin
            // Empty transfer: complete without touching memory.
            state_d = StDone;
          end else begin
            src_d = src;
            dst_d = dst;
            cnt_d = len;
`ifdef DMEM_DMA_FILL_EN
            fill_d = fill;
            if (fill) begin
              data_d  = fill_data;
              state_d = StWr;
            end else begin
              state_d = StRd;
            end
`else
            state_d = StRd;
`endif
          end
        end
      end
      StRd: begin
        if (!mem_stall) begin
          state_d = StCap;
        end
      end
      StCap: begin
        // Read data is valid the cycle after the read was accepted.
        data_d  = mem_data_out;
        state_d = StWr;
      end
      StWr: begin
        if (!mem_stall) begin
          src_d = src_q + WIDTH'(1);
          dst_d = dst_q + WIDTH'(1);
          cnt_d = cnt_q - WIDTH'(1);
          if (cnt_q == WIDTH'(1)) begin
            state_d = StDone;
          end else begin
`ifdef DMEM_DMA_FILL_EN
            state_d = fill_q ? StWr : StRd;
`else
            state_d = StRd;
`endif
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the current state.
  // Requests are gated by rst_n so that a reset issues no further memory access.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_data_in = data_q;
    case (state_q)
      StRd: begin
        busy        = 1'b1;
        mem_read    = rst_n;
        mem_address = src_q;
      end
      StCap: begin
        busy = 1'b1;
      end
      StWr: begin
        busy        = 1'b1;
        mem_write   = rst_n;
        mem_address = dst_q;
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_dma.sv
// Directed self-checking bench for dmem_dma.
// The bench contains a behavioural data memory with a registered read port.
// The fill-mode test is compiled in only when DMEM_DMA_FILL_EN is defined.
module tb_dmem_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] src, dst, len;
  logic        busy, done, mem_write, mem_read, mem_stall;
  logic [15:0] mem_address;
  logic [31:0] mem_data_in, mem_data_out;
`ifdef DMEM_DMA_FILL_EN
  logic        fill;
  logic [31:0] fill_data;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:65535];
  logic [31:0] rdata;

  logic [15:0] addr_log [0:63];
  logic [31:0] din_log  [0:63];
  logic        rd_log   [0:63];
  logic        wr_log   [0:63];
  logic        busy_log [0:63];
  logic        done_log [0:63];
  logic [15:0] rd_addrs [$];

  localparam logic [31:0] WA = 32'h1111_AAAA;
  localparam logic [31:0] WB = 32'h2222_BBBB;
  localparam logic [31:0] WC = 32'h3333_CCCC;
  localparam logic [31:0] WD = 32'h4444_DDDD;

  dmem_dma #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .src          (src),
    .dst          (dst),
    .len          (len),
`ifdef DMEM_DMA_FILL_EN
    .fill         (fill),
    .fill_data    (fill_data),
`endif
    .busy         (busy),
    .done         (done),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_data_out (mem_data_out),
    .mem_stall    (mem_stall)
  );

  always #5 clk = ~clk;

  // Behavioural memory: accepted writes update the array; accepted reads return data next cycle.
  always @(posedge clk) begin
    if (mem_write && !mem_stall) mem[mem_address] <= mem_data_in;
    if (mem_read && !mem_stall) rdata <= mem[mem_address];
  end
  assign mem_data_out = rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one start, then log outputs mid-cycle for cycles 1..budget.
  // Logging stops at the done pulse.
  // stall_mask bit c drives mem_stall in cycle c.
  // rst_cyc >= 1 pulls rst_n low during that cycle.
  task automatic run(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                     input logic [63:0] stall_mask, input int rst_cyc, input int budget,
                     output int done_cyc);
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1; mem_stall = 1'b0;
    rd_addrs.delete();
    for (int i = 0; i < 64; i++) begin
      addr_log[i] = '0; din_log[i] = '0; rd_log[i] = 1'b0;
      wr_log[i] = 1'b0; busy_log[i] = 1'b0; done_log[i] = 1'b0;
    end
    @(posedge clk);
    done_cyc = -1;
    for (int c = 1; c <= budget && c < 64; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == rst_cyc + 1) rst_n = 1'b1;
      if (c == rst_cyc) rst_n = 1'b0;
      mem_stall = stall_mask[c];
      #1;
      addr_log[c] = mem_address; din_log[c] = mem_data_in;
      rd_log[c] = mem_read; wr_log[c] = mem_write;
      busy_log[c] = busy; done_log[c] = done;
      if (mem_read && !mem_stall) rd_addrs.push_back(mem_address);
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    @(negedge clk);
    mem_stall = 1'b0;
  endtask

  initial begin
    int dc;
    int n;
    logic ok;
    rst_n = 1'b0; start = 1'b0; mem_stall = 1'b0;
    src = '0; dst = '0; len = '0; rdata = '0;
`ifdef DMEM_DMA_FILL_EN
    fill = 1'b0; fill_data = '0;
`endif
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd", {31'd0, mem_read}, 32'd0);
    chk("rst_wr", {31'd0, mem_write}, 32'd0);
    chk("rst_addr", {16'd0, mem_address}, 32'd0);
    chk("rst_din", mem_data_in, 32'd0);

    // Basic copy of four words.
    mem[16'h10] = WA; mem[16'h11] = WB; mem[16'h12] = WC; mem[16'h13] = WD;
    run(16'h10, 16'h40, 16'd4, 64'd0, -1, 40, dc);
    chk("copy_done_cyc", dc, 32'd13);
    n = 0;
    for (int c = 1; c <= 13; c++) n += int'(busy_log[c]);
    chk("copy_busy_cnt", n, 32'd12);
    chk("copy_busy_1", {31'd0, busy_log[1]}, 32'd1);
    chk("copy_busy_13", {31'd0, busy_log[13]}, 32'd0);
    chk("copy_w0", mem[16'h40], WA);
    chk("copy_w1", mem[16'h41], WB);
    chk("copy_w2", mem[16'h42], WC);
    chk("copy_w3", mem[16'h43], WD);
    chk("copy_cap_addr", {16'd0, addr_log[2]}, 32'd0);

    // Zero-length start.
    run(16'h10, 16'h70, 16'd0, 64'd0, -1, 10, dc);
    chk("len0_done_cyc", dc, 32'd1);
    chk("len0_no_rdwr", {30'd0, rd_log[1], wr_log[1]}, 32'd0);
    chk("len0_not_busy", {31'd0, busy_log[1]}, 32'd0);

    // Stalls: 2 cycles in the first RD and 3 cycles in the first WR.
    mem[16'h50] = 32'h5A5A_0001;
    run(16'h50, 16'h60, 16'd1, 64'hE6, -1, 30, dc);
    chk("stall_done_cyc", dc, 32'd9);
    ok = 1'b1;
    for (int c = 1; c <= 3; c++) ok &= (addr_log[c] == 16'h50) && rd_log[c] && !wr_log[c];
    chk("stall_rd_hold", {31'd0, ok}, 32'd1);
    ok = 1'b1;
    for (int c = 5; c <= 8; c++)
      ok &= (addr_log[c] == 16'h60) && wr_log[c] && (din_log[c] == 32'h5A5A_0001);
    chk("stall_wr_hold", {31'd0, ok}, 32'd1);
    chk("stall_cap_idle", {30'd0, rd_log[4], wr_log[4]}, 32'd0);
    chk("stall_mem", mem[16'h60], 32'h5A5A_0001);

    // Source address wraps.
    mem[16'hFFFE] = 32'hF00D_0000; mem[16'hFFFF] = 32'hF00D_0001; mem[16'h0000] = 32'hF00D_0002;
    run(16'hFFFE, 16'h0100, 16'd3, 64'd0, -1, 30, dc);
    chk("wrap_done_cyc", dc, 32'd10);
    chk("wrap_nreads", rd_addrs.size(), 32'd3);
    if (rd_addrs.size() == 3) begin
      chk("wrap_rd0", {16'd0, rd_addrs[0]}, 32'hFFFE);
      chk("wrap_rd1", {16'd0, rd_addrs[1]}, 32'hFFFF);
      chk("wrap_rd2", {16'd0, rd_addrs[2]}, 32'h0000);
    end
    chk("wrap_mem2", mem[16'h0102], 32'hF00D_0002);

    // Reset during the second WR (cycle 6) aborts the transfer.
    run(16'h10, 16'h80, 16'd4, 64'd0, 6, 20, dc);
    chk("abort_no_done", dc, 32'hFFFF_FFFF);
    chk("abort_outs", {busy_log[7], done_log[7], rd_log[7], wr_log[7], addr_log[7], din_log[7]},
        32'd0);
    ok = 1'b0;
    for (int c = 7; c <= 20; c++) ok |= rd_log[c] | wr_log[c] | done_log[c];
    chk("abort_quiet", {31'd0, ok}, 32'd0);
    chk("abort_w0", mem[16'h80], WA);
    chk("abort_w1", mem[16'h81], 32'd0);
    run(16'h10, 16'h90, 16'd2, 64'd0, -1, 30, dc);
    chk("after_done_cyc", dc, 32'd7);
    chk("after_w1", mem[16'h91], WB);

`ifdef DMEM_DMA_FILL_EN
    // Fill mode.
    @(negedge clk);
    fill = 1'b1; fill_data = 32'hDEAD_BEEF;
    run(16'h0, 16'h20, 16'd5, 64'd0, -1, 20, dc);
    fill = 1'b0;
    chk("fill_done_cyc", dc, 32'd6);
    ok = 1'b0;
    for (int c = 1; c <= 6; c++) ok |= rd_log[c];
    chk("fill_no_read", {31'd0, ok}, 32'd0);
    for (int i = 0; i < 5; i++) chk("fill_mem", mem[16'h20 + 16'(i)], 32'hDEAD_BEEF);
    chk("fill_mem_past", mem[16'h25], 32'd0);
`endif

    // Overlapping forward copy propagates the first word.
    run(16'h10, 16'h11, 16'd3, 64'd0, -1, 30, dc);
    chk("ovl_done_cyc", dc, 32'd10);
    chk("ovl_m11", mem[16'h11], WA);
    chk("ovl_m13", mem[16'h13], WA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
